// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one combinational adder among NUM_REQ requesters.
// The granted operand pair is steered to the adder; the sum is registered with the winner's ID.
module adder_arbiter #(
  parameter int unsigned BUS_WIDTH = 16,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_ina,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_inb,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [BUS_WIDTH-1:0]         add_ina,
  output logic [BUS_WIDTH-1:0]         add_inb,
  input  logic [BUS_WIDTH-1:0]         add_out,
  output logic                         rsp_valid,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic [BUS_WIDTH-1:0]         rsp_data,
  input  logic                         rsp_ready
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state, state_nxt;
  logic [ID_WIDTH-1:0] rr_ptr, winner, ptr_nxt;
  logic [NUM_REQ-1:0]  grant_oh;
  logic                any_valid, can_accept, accept;

  // Rotating priority search starting at rr_ptr; first valid index wins.
  always_comb begin : grant_search
    int unsigned idx;
    grant_oh  = '0;
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(rr_ptr) + off) % NUM_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid     = 1'b1;
        winner        = ID_WIDTH'(idx);
        grant_oh[idx] = 1'b1;
      end
    end
  end

  assign can_accept = (state == EMPTY) | rsp_ready;
  assign req_ready  = rst ? '0 : (grant_oh & {NUM_REQ{can_accept}});
  assign accept     = |(req_valid & req_ready);
  assign ptr_nxt    = (winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  assign rsp_valid  = (state == FULL);

  // Operands follow the search result even when the result register is busy.
  always_comb begin
    add_ina = '0;
    add_inb = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        add_ina = req_ina[i*BUS_WIDTH +: BUS_WIDTH];
        add_inb = req_inb[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (rsp_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      rr_ptr   <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rsp_data <= add_out;
        rsp_id   <= winner;
        rr_ptr   <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: acts as the shared adder and scores every result
// against the operands the requesters presented.
module tb_adder_arbiter;
  localparam int BW = 16;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR*BW-1:0] req_ina = '0, req_inb = '0;
  logic [NR-1:0] req_ready;
  logic [BW-1:0] add_ina, add_inb, add_out;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [BW-1:0] rsp_data;
  logic          rsp_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [1:0] id; logic [BW-1:0] data; } ent_t;
  ent_t sb[$];
  int   m_ptr  = 0;
  bit   m_full = 0;

  adder_arbiter #(.BUS_WIDTH(BW), .NUM_REQ(NR), .ID_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ina(req_ina), .req_inb(req_inb),
    .req_ready(req_ready), .add_ina(add_ina), .add_inb(add_inb), .add_out(add_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  assign add_out = add_ina + add_inb;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b);
    req_ina[i*BW +: BW] = a;
    req_inb[i*BW +: BW] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Scoreboard: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      check("ready_in_reset", {28'd0, req_ready}, 32'd0);
      sb.delete();
      m_ptr  = 0;
      m_full = 0;
    end else begin
      bit   found;
      bit   can;
      int   win;
      logic [NR-1:0] exp_oh;
      ent_t e;
      found = 0; win = 0; exp_oh = '0;
      can = !m_full || rsp_ready;
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_ptr + k) % NR;
        if (!found && req_valid[j]) begin found = 1; win = j; end
      end
      if (found && can) exp_oh[win] = 1'b1;
      check("req_ready", {28'd0, req_ready}, {28'd0, exp_oh});
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_full});
      if (m_full) begin
        if (sb.size() == 0) check("sb_nonempty", 32'd0, 32'd1);
        else begin
          check("rsp_id", {30'd0, rsp_id}, {30'd0, sb[0].id});
          check("rsp_data", {16'd0, rsp_data}, {16'd0, sb[0].data});
        end
      end
      if (m_full && rsp_ready && sb.size() > 0) void'(sb.pop_front());
      if (found && can) begin
        e.id   = 2'(win);
        e.data = req_ina[win*BW +: BW] + req_inb[win*BW +: BW];
        sb.push_back(e);
        m_ptr  = (win + 1) % NR;
        m_full = 1;
      end else if (m_full && rsp_ready) begin
        m_full = 0;
      end
    end
  end

  initial begin
    logic [NR-1:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
    check("reset_rsp_id", {30'd0, rsp_id}, 32'd0);

    // 1: single request, one-cycle latency
    set_req(0, 16'd3, 16'd4);
    req_valid = 4'b0001;
    #1 check("t1_ready", {28'd0, req_ready}, 32'b0001);
    tick();
    req_valid = '0;
    check("t1_valid", {31'd0, rsp_valid}, 32'd1);
    check("t1_id", {30'd0, rsp_id}, 32'd0);
    check("t1_data", {16'd0, rsp_data}, 32'd7);
    tick();

    // 2: all requesting, round-robin from a fresh pointer
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 16'(100 * (i + 1)), 16'(i + 1));
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1 check("t2_grant", {28'd0, req_ready}, {28'd0, seq[c]});
      tick();
      check("t2_id", {30'd0, rsp_id}, 32'(c % NR));
    end
    req_valid = '0;
    tick();

    // 3: back-pressure holds the result and blocks grants
    rsp_ready = 1'b0;
    set_req(0, 16'd10, 16'd20);
    req_valid = 4'b0001;
    tick();
    set_req(1, 16'd5, 16'd6);
    req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1 check("t3_blocked", {28'd0, req_ready}, 32'd0);
      check("t3_hold_data", {16'd0, rsp_data}, 32'd30);
      check("t3_hold_valid", {31'd0, rsp_valid}, 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    #1 check("t3_release", {28'd0, req_ready}, 32'b0010);
    tick();
    req_valid = '0;
    check("t3_id", {30'd0, rsp_id}, 32'd1);
    check("t3_data", {16'd0, rsp_data}, 32'd11);

    // 4: modulo wrap of the sum
    set_req(0, 16'hFFFF, 16'h0002);
    req_valid = 4'b0001;
    tick();
    check("t4_wrap1", {16'd0, rsp_data}, 32'h0001);
    set_req(0, 16'h8000, 16'h8000);
    tick();
    check("t4_wrap2", {16'd0, rsp_data}, 32'h0000);
    req_valid = '0;
    tick();

    // 5: pointer wrap after a grant to requester 2
    set_req(2, 16'd7, 16'd8);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0101;
    #1 check("t5_wrap0", {28'd0, req_ready}, 32'b0001);
    tick();
    #1 check("t5_then2", {28'd0, req_ready}, 32'b0100);
    tick();
    req_valid = 4'b0100;
    #1 check("t5_lone2", {28'd0, req_ready}, 32'b0100);
    tick();
    req_valid = '0;
    tick();

    // 6: asynchronous reset mid-burst
    req_valid = 4'b1111;
    tick();
    tick();
    #1 rst = 1'b1;
    #1 check("t6_async_valid", {31'd0, rsp_valid}, 32'd0);
    check("t6_async_ready", {28'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = 4'b0110;
    #1 check("t6_first", {28'd0, req_ready}, 32'b0010);
    tick();
    check("t6_id", {30'd0, rsp_id}, 32'd1);
    req_valid = '0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
